// File: rtl/triangle_bbox_scanner.sv
// Scans the axis-aligned bounding box of one triangle in row-major order and
// emits one pixel beat per coordinate, all beats carrying the triangle's color.
module triangle_bbox_scanner (
  input  logic          clk,
  input  logic          rst,
  input  logic          texel_ready,
  input  logic [143:0]  texel_vertices_in,
  input  logic [23:0]   texel_color_in,
  output logic          texel_read,
  input  logic          pixel_ready,
  output logic          pixel_valid,
  output logic [15:0]   pixel_x,
  output logic [15:0]   pixel_y,
  output logic [23:0]   pixel_color,
  output logic          pixel_first,
  output logic          pixel_last,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ACK, SCAN} state_t;

  state_t      state_q, state_d;
  logic [15:0] px_q, py_q, qx_q, qy_q, rx_q, ry_q;
  logic [15:0] px_d, py_d, qx_d, qy_d, rx_d, ry_d;
  logic [23:0] color_q, color_d;
  logic [15:0] xmin_q, xmax_q, ymin_q, ymax_q;
  logic [15:0] xmin_d, xmax_d, ymin_d, ymax_d;
  logic [15:0] pix_x_q, pix_y_q, pix_x_d, pix_y_d;
  logic        first_q, first_d, last_q, last_d;

  logic [15:0] xmin_c, xmax_c, ymin_c, ymax_c;
  logic [15:0] next_x, next_y;

  function automatic logic [15:0] min3(input logic [15:0] a, b, c);
    logic [15:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic logic [15:0] max3(input logic [15:0] a, b, c);
    logic [15:0] m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  always_comb begin
    state_d = state_q;
    px_d    = px_q;
    py_d    = py_q;
    qx_d    = qx_q;
    qy_d    = qy_q;
    rx_d    = rx_q;
    ry_d    = ry_q;
    color_d = color_q;
    xmin_d  = xmin_q;
    xmax_d  = xmax_q;
    ymin_d  = ymin_q;
    ymax_d  = ymax_q;
    pix_x_d = pix_x_q;
    pix_y_d = pix_y_q;
    first_d = first_q;
    last_d  = last_q;

    xmin_c = min3(px_q, qx_q, rx_q);
    xmax_c = max3(px_q, qx_q, rx_q);
    ymin_c = min3(py_q, qy_q, ry_q);
    ymax_c = max3(py_q, qy_q, ry_q);

    // The counter only steps while it is strictly below its bound, so a
    // bound of 0xFFFF can never wrap back to zero.
    if (pix_x_q != xmax_q) begin
      next_x = pix_x_q + 16'd1;
      next_y = pix_y_q;
    end else begin
      next_x = xmin_q;
      next_y = pix_y_q + 16'd1;
    end

    case (state_q)
      IDLE: begin
        if (texel_ready) begin
          px_d    = texel_vertices_in[143:128];
          py_d    = texel_vertices_in[127:112];
          qx_d    = texel_vertices_in[95:80];
          qy_d    = texel_vertices_in[79:64];
          rx_d    = texel_vertices_in[47:32];
          ry_d    = texel_vertices_in[31:16];
          color_d = texel_color_in;
          state_d = ACK;
        end
      end
      ACK: begin
        xmin_d  = xmin_c;
        xmax_d  = xmax_c;
        ymin_d  = ymin_c;
        ymax_d  = ymax_c;
        pix_x_d = xmin_c;
        pix_y_d = ymin_c;
        first_d = 1'b1;
        last_d  = (xmin_c == xmax_c) && (ymin_c == ymax_c);
        state_d = SCAN;
      end
      SCAN: begin
        if (pixel_ready) begin
          first_d = 1'b0;
          if (last_q) begin
            last_d  = 1'b0;
            state_d = IDLE;
          end else begin
            pix_x_d = next_x;
            pix_y_d = next_y;
            last_d  = (next_x == xmax_q) && (next_y == ymax_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      px_q    <= '0;
      py_q    <= '0;
      qx_q    <= '0;
      qy_q    <= '0;
      rx_q    <= '0;
      ry_q    <= '0;
      color_q <= '0;
      xmin_q  <= '0;
      xmax_q  <= '0;
      ymin_q  <= '0;
      ymax_q  <= '0;
      pix_x_q <= '0;
      pix_y_q <= '0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      px_q    <= px_d;
      py_q    <= py_d;
      qx_q    <= qx_d;
      qy_q    <= qy_d;
      rx_q    <= rx_d;
      ry_q    <= ry_d;
      color_q <= color_d;
      xmin_q  <= xmin_d;
      xmax_q  <= xmax_d;
      ymin_q  <= ymin_d;
      ymax_q  <= ymax_d;
      pix_x_q <= pix_x_d;
      pix_y_q <= pix_y_d;
      first_q <= first_d;
      last_q  <= last_d;
    end
  end

  // Handshake flags decode from the state register alone.
  assign texel_read  = (state_q == ACK);
  assign pixel_valid = (state_q == SCAN);
  assign busy        = (state_q != IDLE);
  assign pixel_x     = pix_x_q;
  assign pixel_y     = pix_y_q;
  assign pixel_color = color_q;
  assign pixel_first = first_q;
  assign pixel_last  = last_q;

endmodule

// File: tb/tb_triangle_bbox_scanner.sv
// Directed and randomized checks of triangle_bbox_scanner against a
// bounding-box reference model built from nested coordinate loops.
module tb_triangle_bbox_scanner;

  logic          clk = 1'b0;
  logic          rst;
  logic          texel_ready;
  logic [143:0]  texel_vertices_in;
  logic [23:0]   texel_color_in;
  logic          texel_read;
  logic          pixel_ready;
  logic          pixel_valid;
  logic [15:0]   pixel_x;
  logic [15:0]   pixel_y;
  logic [23:0]   pixel_color;
  logic          pixel_first;
  logic          pixel_last;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  triangle_bbox_scanner dut (
    .clk               (clk),
    .rst               (rst),
    .texel_ready       (texel_ready),
    .texel_vertices_in (texel_vertices_in),
    .texel_color_in    (texel_color_in),
    .texel_read        (texel_read),
    .pixel_ready       (pixel_ready),
    .pixel_valid       (pixel_valid),
    .pixel_x           (pixel_x),
    .pixel_y           (pixel_y),
    .pixel_color       (pixel_color),
    .pixel_first       (pixel_first),
    .pixel_last        (pixel_last),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_texel_read"}, {31'd0, texel_read}, 32'd0);
    checkOutput({tag, "_valid"},      {31'd0, pixel_valid}, 32'd0);
    checkOutput({tag, "_first"},      {31'd0, pixel_first}, 32'd0);
    checkOutput({tag, "_last"},       {31'd0, pixel_last}, 32'd0);
    checkOutput({tag, "_busy"},       {31'd0, busy}, 32'd0);
    checkOutput({tag, "_x"},          {16'd0, pixel_x}, 32'd0);
    checkOutput({tag, "_y"},          {16'd0, pixel_y}, 32'd0);
    checkOutput({tag, "_color"},      {8'd0, pixel_color}, 32'd0);
  endtask

  function automatic logic [143:0] packTri(input int px, py, qx, qy, rx, ry);
    logic [15:0] z;
    z = 16'($urandom);
    return {16'(px), 16'(py), z, 16'(qx), 16'(qy), z, 16'(rx), 16'(ry), z};
  endfunction

  task automatic applyStimulus(input logic [143:0] verts, input logic [23:0] color);
    texel_vertices_in = verts;
    texel_color_in    = color;
    texel_ready       = 1'b1;
    pixel_ready       = 1'b0;
  endtask

  // mode 0: ready always high, 1: ready pattern 1,0,0,..., 2: random ready.
  // abort_at >= 0 asserts reset while that beat index is presented.
  task automatic runTriangle(input int px, py, qx, qy, rx, ry, input logic [23:0] color,
                             input int mode, input int abort_at);
    logic [31:0] exp_beats[$];
    int xmin, xmax, ymin, ymax, n, idx, k;
    bit aborted;
    xmin = (px < qx) ? px : qx;  xmin = (rx < xmin) ? rx : xmin;
    xmax = (px > qx) ? px : qx;  xmax = (rx > xmax) ? rx : xmax;
    ymin = (py < qy) ? py : qy;  ymin = (ry < ymin) ? ry : ymin;
    ymax = (py > qy) ? py : qy;  ymax = (ry > ymax) ? ry : ymax;
    for (int y = ymin; y <= ymax; y++)
      for (int x = xmin; x <= xmax; x++)
        exp_beats.push_back({16'(x), 16'(y)});
    n = exp_beats.size();

    applyStimulus(packTri(px, py, qx, qy, rx, ry), color);
    checkOutput("pre_read", {31'd0, texel_read}, 32'd0);
    @(posedge clk); #1;
    checkOutput("ack_read",  {31'd0, texel_read}, 32'd1);
    checkOutput("ack_busy",  {31'd0, busy}, 32'd1);
    checkOutput("ack_valid", {31'd0, pixel_valid}, 32'd0);
    @(posedge clk); #1;
    checkOutput("scan_read", {31'd0, texel_read}, 32'd0);

    idx = 0;
    k = 0;
    aborted = 1'b0;
    while (!aborted && idx < n && k < 4 * n + 20) begin
      case (mode)
        0:       pixel_ready = 1'b1;
        1:       pixel_ready = (k % 3 == 0);
        default: pixel_ready = 1'($urandom_range(0, 1));
      endcase
      if (abort_at == idx) begin
        texel_ready = 1'b0;
        rst = 1'b1;
        #1;
        checkAllZero("abort");
        #1;
        rst = 1'b0;
        aborted = 1'b1;
      end else begin
        checkOutput("beat_valid", {31'd0, pixel_valid}, 32'd1);
        checkOutput("beat_busy",  {31'd0, busy}, 32'd1);
        checkOutput("beat_x",     {16'd0, pixel_x}, {16'd0, exp_beats[idx][31:16]});
        checkOutput("beat_y",     {16'd0, pixel_y}, {16'd0, exp_beats[idx][15:0]});
        checkOutput("beat_color", {8'd0, pixel_color}, {8'd0, color});
        checkOutput("beat_first", {31'd0, pixel_first}, {31'd0, idx == 0});
        checkOutput("beat_last",  {31'd0, pixel_last}, {31'd0, idx == n - 1});
        if (pixel_ready) begin
          idx++;
          if (idx == n) texel_ready = 1'b0;
        end
        @(posedge clk); #1;
        k++;
      end
    end

    if (!aborted) begin
      checkOutput("beat_count", idx, n);
      if (idx != n) texel_ready = 1'b0;
      checkOutput("end_valid", {31'd0, pixel_valid}, 32'd0);
      checkOutput("end_busy",  {31'd0, busy}, 32'd0);
      checkOutput("end_read",  {31'd0, texel_read}, 32'd0);
    end
    pixel_ready = 1'b0;
    @(posedge clk); #1;
    checkOutput("idle_busy",  {31'd0, busy}, 32'd0);
    checkOutput("idle_valid", {31'd0, pixel_valid}, 32'd0);
  endtask

  initial begin
    rst               = 1'b1;
    texel_ready       = 1'b0;
    texel_vertices_in = '0;
    texel_color_in    = '0;
    pixel_ready       = 1'b0;
    #2;
    checkAllZero("por");
    #10;
    rst = 1'b0;

    $display("[TB] basic 3x2 box, ready always high");
    runTriangle(2, 3, 4, 3, 3, 4, 24'h112233, 0, -1);
    $display("[TB] same box, ready pattern 1,0,0");
    runTriangle(2, 3, 4, 3, 3, 4, 24'h112233, 1, -1);
    $display("[TB] degenerate box");
    runTriangle(5, 5, 5, 5, 5, 5, 24'hA5A5A5, 0, -1);
    $display("[TB] box at the 0xFFFF edge");
    runTriangle(16'hFFFF, 0, 16'hFFFE, 1, 16'hFFFF, 1, 24'h0F0F0F, 2, -1);
    $display("[TB] reset during beat 3, then single-pixel triangle");
    runTriangle(2, 3, 4, 3, 3, 4, 24'h112233, 0, 2);
    runTriangle(1, 1, 1, 1, 1, 1, 24'h445566, 0, -1);

    $display("[TB] randomized triangles");
    for (int t = 0; t < 25; t++) begin
      int bx, by;
      bx = ($urandom_range(0, 3) == 0) ? 16'hFFFA : $urandom_range(0, 16'hFF00);
      by = ($urandom_range(0, 3) == 0) ? 16'hFFFA : $urandom_range(0, 16'hFF00);
      runTriangle(bx + $urandom_range(0, 5), by + $urandom_range(0, 5),
                  bx + $urandom_range(0, 5), by + $urandom_range(0, 5),
                  bx + $urandom_range(0, 5), by + $urandom_range(0, 5),
                  24'($urandom), $urandom_range(0, 2), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
